div_sequencer: RTL and testbench

Multi-cycle sequencer for the execute stage's shared divider. It accepts a signed or unsigned 32-bit divide request, drives the pipelined divider core for a fixed latency, and holds the requester until quotient and remainder are ready. It then presents the result with a valid/hold handshake toward the write stage. It replaces the ad-hoc delay shift register in execute with an explicit FSM and counter.

---
 rtl/div_sequencer_pkg.sv | 19 +
 rtl/div_sequencer_if.sv | 29 ++
 rtl/div_sequencer_core.sv | 59 +++++
 rtl/div_sequencer.sv | 128 ++++++++++++
 tb/tb_div_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the divide sequencer and its divider core.
package div_sequencer_pkg;

    typedef logic [31:0] regval_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_MAX_LATENCY = 8;
    localparam int DIV_CNT_W       = $clog2(DIV_MAX_LATENCY);

    function automatic regval_t neg_if(input regval_t v, input logic neg);
        return neg ? regval_t'(-v) : v;
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/result bundle between the execute stage, the divide sequencer and the write stage.
interface div_sequencer_if;
    import div_sequencer_pkg::*;

    // Request: req_valid with operands stable while req_hold=1; the request is
    // consumed on the edge where req_valid=1 and req_hold=0.
    // Result: res_valid marks a completed divide; it retires on an edge with res_hold=0.
    logic    req_valid;
    logic    req_signed;
    regval_t req_numer;
    regval_t req_denom;
    logic    req_hold;
    logic    res_valid;
    logic    res_hold;
    regval_t res_quotient;
    regval_t res_remainder;
    logic    res_div_zero;

    modport master (
        output req_valid, req_signed, req_numer, req_denom, res_hold,
        input  req_hold, res_valid, res_quotient, res_remainder, res_div_zero
    );

    modport slave (
        input  req_valid, req_signed, req_numer, req_denom, res_hold,
        output req_hold, res_valid, res_quotient, res_remainder, res_div_zero
    );

endinterface

// File: rtl/div_sequencer_core.sv
// div_core: signed and unsigned dividers on registered operands, delayed through
// LATENCY-1 pipeline stages so the sequencer samples the result LATENCY edges after capture.
module div_core
    import div_sequencer_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    op_signed_i,
    input  regval_t numer_i,
    input  regval_t denom_i,
    output regval_t quot_o,
    output regval_t rem_o
);

    regval_t u_quot, u_rem, s_quot, s_rem, n_mag, d_mag;
    logic    n_neg, d_neg;
    logic [63:0] result;

    // A zero divisor yields all-ones quotient and the numerator as remainder in both modes.
    always_comb begin
        n_neg  = numer_i[31];
        d_neg  = denom_i[31];
        n_mag  = neg_if(numer_i, n_neg);
        d_mag  = neg_if(denom_i, d_neg);
        u_quot = '1;
        u_rem  = numer_i;
        s_quot = '1;
        s_rem  = numer_i;
        if (denom_i != '0) begin
            u_quot = numer_i / denom_i;
            u_rem  = numer_i % denom_i;
            s_quot = neg_if(n_mag / d_mag, n_neg ^ d_neg);
            s_rem  = neg_if(n_mag % d_mag, n_neg);
        end
        result = op_signed_i ? {s_quot, s_rem} : {u_quot, u_rem};
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [63:0] pipe_q [LATENCY-1];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= result;
                    for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign {quot_o, rem_o} = pipe_q[LATENCY-2];
        end else begin : g_direct
            assign {quot_o, rem_o} = result;
        end
    endgenerate

endmodule

// File: rtl/div_sequencer.sv
// Divide sequencer: IDLE/RUN/DONE FSM driving div_core for LATENCY cycles.
// Optional DIV_ZERO_SHORTCUT_EN: zero-denominator requests skip RUN and complete at accept.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    div_sequencer_if.slave bus,
    output logic         busy,
    output div_state_t   state_o
);

    localparam logic [DIV_CNT_W-1:0] CNT_START = DIV_CNT_W'(LATENCY - 1);

    div_state_t             state_q, state_d;
    logic [DIV_CNT_W-1:0]   count_q, count_d;
    logic                   op_signed_q, op_signed_d;
    regval_t                op_numer_q, op_numer_d;
    regval_t                op_denom_q, op_denom_d;
    logic                   res_valid_q, res_valid_d;
    regval_t                res_quot_q, res_quot_d;
    regval_t                res_rem_q, res_rem_d;
    logic                   res_dz_q, res_dz_d;
    logic                   busy_q, busy_d;
    regval_t                core_quot, core_rem;

    div_core #(.LATENCY(LATENCY)) u_div_core (
        .clock       (clock),
        .reset_n     (reset_n),
        .op_signed_i (op_signed_q),
        .numer_i     (op_numer_q),
        .denom_i     (op_denom_q),
        .quot_o      (core_quot),
        .rem_o       (core_rem)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            op_signed_q <= 1'b0;
            op_numer_q  <= '0;
            op_denom_q  <= '0;
            res_valid_q <= 1'b0;
            res_quot_q  <= '0;
            res_rem_q   <= '0;
            res_dz_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op_signed_q <= op_signed_d;
            op_numer_q  <= op_numer_d;
            op_denom_q  <= op_denom_d;
            res_valid_q <= res_valid_d;
            res_quot_q  <= res_quot_d;
            res_rem_q   <= res_rem_d;
            res_dz_q    <= res_dz_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        op_signed_d = op_signed_q;
        op_numer_d  = op_numer_q;
        op_denom_d  = op_denom_q;
        res_quot_d  = res_quot_q;
        res_rem_d   = res_rem_q;
        res_dz_d    = res_dz_q;

        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_signed_d = bus.req_signed;
                        op_numer_d  = bus.req_numer;
                        op_denom_d  = bus.req_denom;
                        state_d     = RUN;
                        count_d     = CNT_START;
`ifdef DIV_ZERO_SHORTCUT_EN
                        if (bus.req_denom == '0) begin
                            state_d    = DONE;
                            count_d    = '0;
                            res_quot_d = '1;
                            res_rem_d  = bus.req_numer;
                            res_dz_d   = 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    if (count_q != '0) begin
                        count_d = count_q - DIV_CNT_W'(1);
                    end else begin
                        res_quot_d = core_quot;
                        res_rem_d  = core_rem;
                        res_dz_d   = (op_denom_q == '0);
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    if (!bus.res_hold) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign bus.req_hold      = bus.req_valid && !(state_q == DONE && !bus.res_hold);
    assign bus.res_valid     = res_valid_q;
    assign bus.res_quotient  = res_quot_q;
    assign bus.res_remainder = res_rem_q;
    assign bus.res_div_zero  = res_dz_q;
    assign busy              = busy_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: vector table, random unsigned divides and hand-written corner sequences.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int LATENCY = 4;
    localparam int WAIT_MAX = 32;

    typedef struct {
        logic        sgn;
        logic [31:0] numer;
        logic [31:0] denom;
        logic [31:0] quot;
        logic [31:0] rem;
        logic        dz;
        int          hold;
    } vec_t;

    logic       clock, reset_n, flush, busy;
    div_state_t state_o;
    int         errors = 0;
    int         checks = 0;
    logic [64:0] exp_q[$];
    logic       mon_prev = 1'b0;

    div_sequencer_if bus();

    div_sequencer #(.LATENCY(LATENCY)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus),
        .busy    (busy),
        .state_o (state_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each result is compared once, on the first cycle res_valid is seen.
    always @(negedge clock) begin
        logic [64:0] e;
        if (bus.res_valid && !mon_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got q=%h r=%h with empty queue", bus.res_quotient, bus.res_remainder);
            end else begin
                e = exp_q.pop_front();
                chk("quotient", bus.res_quotient, e[64:33]);
                chk("remainder", bus.res_remainder, e[32:1]);
                chk("div_zero", {31'd0, bus.res_div_zero}, {31'd0, e[0]});
            end
        end
        mon_prev = bus.res_valid;
    end

    task automatic drive(input vec_t v);
        bus.req_valid  = 1'b1;
        bus.req_signed = v.sgn;
        bus.req_numer  = v.numer;
        bus.req_denom  = v.denom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.res_valid && lat < WAIT_MAX) begin
            chk("req_hold_run", {31'd0, bus.req_hold}, 32'd1);
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic recover();
        bus.req_valid = 1'b0;
        bus.res_hold  = 1'b0;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_div(input vec_t v);
        int lat, exp_lat;
        exp_lat = LATENCY;
`ifdef DIV_ZERO_SHORTCUT_EN
        if (v.denom == 32'd0) exp_lat = 0;
`endif
        @(negedge clock);
        drive(v);
        bus.res_hold = (v.hold > 0);
        exp_q.push_back({v.quot, v.rem, v.dz});
        #1 chk("req_hold_idle", {31'd0, bus.req_hold}, 32'd1);
        @(posedge clock); #1;
        chk("busy_accept", {31'd0, busy}, 32'd1);
        wait_valid(lat);
        chk("latency", 32'(lat), 32'(exp_lat));
        if (!bus.res_valid) begin
            recover();
            return;
        end
        chk("req_hold_done", {31'd0, bus.req_hold}, (v.hold > 0) ? 32'd1 : 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clock); #1;
            chk("hold_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("hold_quot", bus.res_quotient, v.quot);
            chk("hold_rem", bus.res_remainder, v.rem);
            chk("hold_req_hold", {31'd0, bus.req_hold}, 32'd1);
        end
        bus.res_hold = 1'b0;
        #1 chk("req_hold_release", {31'd0, bus.req_hold}, 32'd0);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        chk("retire_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("retire_busy", {31'd0, busy}, 32'd0);
        chk("retire_state", 32'(state_o), 32'(IDLE));
    endtask

    initial begin
        vec_t vecs[12];
        vec_t r;
        int lat;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 3};
        vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 0};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0, 0};
        vecs[4]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1};
        vecs[5]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 0};
        vecs[6]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 0};
        vecs[7]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 0};
        vecs[8]  = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 0};
        vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 0};
        vecs[10] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 0};
        vecs[11] = '{1'b1, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 2};

        reset_n        = 1'b0;
        flush          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_numer  = '0;
        bus.req_denom  = '0;
        bus.res_hold   = 1'b0;
        #2;
        chk("rst_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_quot", bus.res_quotient, 32'd0);
        chk("rst_rem", bus.res_remainder, 32'd0);
        chk("rst_dz", {31'd0, bus.res_div_zero}, 32'd0);
        chk("rst_state", 32'(state_o), 32'(IDLE));
        chk("rst_req_hold", {31'd0, bus.req_hold}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 12; i++) run_div(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            r.sgn   = 1'b0;
            r.numer = $urandom;
            r.denom = $urandom_range(1, 1000);
            r.quot  = r.numer / r.denom;
            r.rem   = r.numer % r.denom;
            r.dz    = 1'b0;
            r.hold  = $urandom_range(0, 2);
            run_div(r);
        end

        // Flush beats a simultaneous request in IDLE.
        @(negedge clock);
        drive(vecs[0]);
        flush = 1'b1;
        @(posedge clock); #1;
        chk("flush_idle_state", 32'(state_o), 32'(IDLE));
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);
        flush = 1'b0;

        // Flush during RUN: back to IDLE, no result ever appears.
        @(negedge clock);
        drive(vecs[3]);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_run_state", 32'(state_o), 32'(IDLE));
        chk("flush_run_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < LATENCY + 2; i++) begin
            @(posedge clock); #1;
            chk("flush_no_valid", {31'd0, bus.res_valid}, 32'd0);
        end
        run_div(vecs[9]);

        // Asynchronous reset in the middle of RUN.
        @(negedge clock);
        drive(vecs[0]);
        @(posedge clock);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_quot", bus.res_quotient, 32'd0);
        chk("arst_rem", bus.res_remainder, 32'd0);
        chk("arst_state", 32'(state_o), 32'(IDLE));
        bus.req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // Back-to-back requests: exactly one IDLE cycle between retire and the next accept.
        @(negedge clock);
        drive(vecs[5]);
        exp_q.push_back({vecs[5].quot, vecs[5].rem, vecs[5].dz});
        @(posedge clock); #1;
        wait_valid(lat);
        chk("b2b_lat_a", 32'(lat), 32'(LATENCY));
        @(posedge clock); #1;
        drive(vecs[10]);
        exp_q.push_back({vecs[10].quot, vecs[10].rem, vecs[10].dz});
        chk("b2b_gap_state", 32'(state_o), 32'(IDLE));
        chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
        chk("b2b_gap_req_hold", {31'd0, bus.req_hold}, 32'd1);
        @(posedge clock); #1;
        chk("b2b_accept_state", 32'(state_o), 32'(RUN));
        wait_valid(lat);
        chk("b2b_lat_b", 32'(lat), 32'(LATENCY));
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        chk("b2b_retire_state", 32'(state_o), 32'(IDLE));
        @(posedge clock); #1;
        chk("b2b_stay_idle", 32'(state_o), 32'(IDLE));

        repeat (2) @(posedge clock);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
